// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote result announcer: FSM state encoding,
// default frame header, candidate id bytes and the frame-length helper.
//
// Optional build macro: VOTE_RESULT_CHECKSUM_EN
//   When defined, every frame carries one extra trailing XOR checksum byte,
//   and frame_len() accounts for it.
// ---------------------------------------------------------------------------
package vote_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CMP1,
    CMP2,
    SEND,
    DONE
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam int NUM_CAND = 3;

  localparam logic [7:0] CAND_ID1 = 8'h01;
  localparam logic [7:0] CAND_ID2 = 8'h02;
  localparam logic [7:0] CAND_ID3 = 8'h03;

  // Wide enough for the longest frame (18 bytes at COUNT_W=32 with checksum)
  localparam int IDX_W = 5;

  // Candidate number (1..NUM_CAND) to its id byte in the frame
  function automatic logic [7:0] cand_id(input int c);
    case (c)
      1:       return CAND_ID1;
      2:       return CAND_ID2;
      3:       return CAND_ID3;
      default: return 8'h00;
    endcase
  endfunction

  // Header + per candidate (id + count bytes) + winner [+ checksum]
  function automatic int frame_len(input int count_w);
`ifdef VOTE_RESULT_CHECKSUM_EN
    return 3 + NUM_CAND * (1 + count_w / 8);
`else
    return 2 + NUM_CAND * (1 + count_w / 8);
`endif
  endfunction

endpackage

// File: rtl/vote_frame_mux.sv
// ---------------------------------------------------------------------------
// vote_frame_mux
// Purely combinational byte selector for the result frame. Given the current
// byte index it returns the matching frame byte built from the latched counts,
// the resolved winner and (optionally) the running checksum.
//
// Frame layout: HEADER, {id c, count c MSB first} for c=1..3, winner [, chk]
//
// Ports:
//   i_idx      in   IDX_W    byte index within the frame
//   i_count1   in   COUNT_W  latched candidate 1 count
//   i_count2   in   COUNT_W  latched candidate 2 count
//   i_count3   in   COUNT_W  latched candidate 3 count
//   i_winner   in   2        resolved winner (0 = tie)
//   i_chk      in   8        running XOR (only with VOTE_RESULT_CHECKSUM_EN)
//   o_data     out  8        selected frame byte (0 for out-of-range index)
//
// Optional build macro: VOTE_RESULT_CHECKSUM_EN
// ---------------------------------------------------------------------------
module vote_frame_mux
  import vote_pkg::*;
#(
  parameter int         COUNT_W = 32,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [COUNT_W-1:0] i_count1,
  input  logic [COUNT_W-1:0] i_count2,
  input  logic [COUNT_W-1:0] i_count3,
  input  logic [1:0]         i_winner,
`ifdef VOTE_RESULT_CHECKSUM_EN
  input  logic [7:0]         i_chk,
`endif
  output logic [7:0]         o_data
);

  localparam int NB        = COUNT_W / 8;
  localparam int FRAME_LEN = frame_len(COUNT_W);
  localparam int WIN_IDX   = 1 + NUM_CAND * (1 + NB);

  logic [COUNT_W-1:0] w_cnt   [NUM_CAND];
  logic [7:0]         w_table [FRAME_LEN];

  assign w_cnt[0] = i_count1;
  assign w_cnt[1] = i_count2;
  assign w_cnt[2] = i_count3;

  // The whole frame is laid out as a constant-indexed table so that the
  // runtime selection below is a single array lookup.
  assign w_table[0] = HEADER;

  for (genvar c = 0; c < NUM_CAND; c++) begin : g_cand
    assign w_table[c*(1+NB)+1] = cand_id(c + 1);
    for (genvar b = 0; b < NB; b++) begin : g_byte
      assign w_table[c*(1+NB)+2+b] = w_cnt[c][(NB-1-b)*8 +: 8];
    end
  end

  assign w_table[WIN_IDX] = {6'b000000, i_winner};

`ifdef VOTE_RESULT_CHECKSUM_EN
  assign w_table[WIN_IDX+1] = i_chk;
`endif

  // Index past the end of the frame reads as zero rather than X
  always_comb begin
    o_data = 8'h00;
    if (i_idx < IDX_W'(FRAME_LEN)) begin
      o_data = w_table[i_idx];
    end
  end

endmodule

// File: rtl/vote_result_tx.sv
// ---------------------------------------------------------------------------
// vote_result_tx
// Announcer for the voting machine tallies. On the rising edge of
// i_voting_over it latches the three counts, resolves the winner (or a tie)
// over two compare cycles, then streams a byte frame over a valid/ready link
// and returns to idle after a one-cycle done pulse.
//
// Ports:
//   clk            in   1        system clock
//   rst            in   1        synchronous active-high reset
//   i_voting_over  in   1        voting finished (rising edge starts a frame)
//   i_count1..3    in   COUNT_W  candidate tallies
//   o_tx_data      out  8        frame byte
//   o_tx_valid     out  1        o_tx_data valid
//   i_tx_ready     in   1        downstream accepts when valid & ready
//   o_winner       out  2        1..3 winner, 0 = tie / no result
//   o_busy         out  1        high from LATCH through SEND
//   o_done         out  1        one-cycle pulse after last byte accepted
//
// Optional build macro: VOTE_RESULT_CHECKSUM_EN
//   Appends an XOR-of-all-previous-bytes checksum as the final frame byte.
// ---------------------------------------------------------------------------
module vote_result_tx
  import vote_pkg::*;
#(
  parameter int         COUNT_W = 32,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_voting_over,
  input  logic [COUNT_W-1:0] i_count1,
  input  logic [COUNT_W-1:0] i_count2,
  input  logic [COUNT_W-1:0] i_count3,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [1:0]         o_winner,
  output logic               o_busy,
  output logic               o_done
);

  localparam int LAST_IDX = frame_len(COUNT_W) - 1;

  // Only whole-byte count widths up to 32 bits are supported
  if (!(COUNT_W == 8 || COUNT_W == 16 || COUNT_W == 24 || COUNT_W == 32)) begin : g_bad_count_w
    $error("vote_result_tx: COUNT_W must be 8, 16, 24 or 32");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic               r_prev_over;
  logic [COUNT_W-1:0] r_cnt1;
  logic [COUNT_W-1:0] r_cnt2;
  logic [COUNT_W-1:0] r_cnt3;
  logic [COUNT_W-1:0] r_max12;
  logic [1:0]         r_max12_id;
  logic               r_eq12;
  logic [1:0]         r_winner;
  logic [IDX_W-1:0]   r_idx;
`ifdef VOTE_RESULT_CHECKSUM_EN
  logic [7:0]         r_chk;
`endif

  logic               w_start;
  logic               w_hs;
  logic               w_last;
  logic [7:0]         w_tx_data;

  assign w_start  = i_voting_over & ~r_prev_over;
  assign w_hs     = (r_state == SEND) & i_tx_ready;
  assign w_last   = (r_idx == IDX_W'(LAST_IDX));
  assign o_winner = r_winner;

  // Data is forced to zero outside SEND so the idle/reset output is all zeros
  assign o_tx_data = o_tx_valid ? w_tx_data : 8'h00;

  vote_frame_mux #(
    .COUNT_W (COUNT_W),
    .HEADER  (HEADER)
  ) u_frame_mux (
    .i_idx    (r_idx),
    .i_count1 (r_cnt1),
    .i_count2 (r_cnt2),
    .i_count3 (r_cnt3),
    .i_winner (r_winner),
`ifdef VOTE_RESULT_CHECKSUM_EN
    .i_chk    (r_chk),
`endif
    .o_data   (w_tx_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Previous voting-over level. It tracks the input in every state, so an
  // edge seen while busy is consumed and never queued for a later frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_over <= 1'b0;
    end else begin
      r_prev_over <= i_voting_over;
    end
  end

  // Next-state and Moore outputs. SEND only leaves after the final byte's
  // handshake, so valid and data stay put across any ready stall.
  always_comb begin
    w_next_state = r_state;
    o_tx_valid   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = LATCH;
        end
      end
      LATCH: begin
        o_busy       = 1'b1;
        w_next_state = CMP1;
      end
      CMP1: begin
        o_busy       = 1'b1;
        w_next_state = CMP2;
      end
      CMP2: begin
        o_busy       = 1'b1;
        w_next_state = SEND;
      end
      SEND: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        if (w_hs && w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: count capture, two-step winner resolution and byte indexing.
  // The winner is resolved as a pairwise max of 1/2 first, then against 3;
  // any equality at the top value collapses the result to 0 (tie).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt1     <= '0;
      r_cnt2     <= '0;
      r_cnt3     <= '0;
      r_max12    <= '0;
      r_max12_id <= 2'd0;
      r_eq12     <= 1'b0;
      r_winner   <= 2'd0;
      r_idx      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt1   <= i_count1;
            r_cnt2   <= i_count2;
            r_cnt3   <= i_count3;
            r_winner <= 2'd0;
          end
        end
        CMP1: begin
          if (r_cnt1 >= r_cnt2) begin
            r_max12    <= r_cnt1;
            r_max12_id <= 2'd1;
          end else begin
            r_max12    <= r_cnt2;
            r_max12_id <= 2'd2;
          end
          r_eq12 <= (r_cnt1 == r_cnt2);
        end
        CMP2: begin
          if (r_cnt3 > r_max12) begin
            r_winner <= 2'd3;
          end else if (r_cnt3 == r_max12 || r_eq12) begin
            r_winner <= 2'd0;
          end else begin
            r_winner <= r_max12_id;
          end
          r_idx <= '0;
        end
        SEND: begin
          if (w_hs) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef VOTE_RESULT_CHECKSUM_EN
  // Running XOR of every byte accepted so far; at the checksum index it
  // already holds the XOR of all preceding bytes, header included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk <= 8'h00;
    end else if (r_state == CMP2) begin
      r_chk <= 8'h00;
    end else if (w_hs) begin
      r_chk <= r_chk ^ w_tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_vote_result_tx.sv
// ---------------------------------------------------------------------------
// tb_vote_result_tx
// Scoreboard bench for vote_result_tx. Stimulus pushes the expected frame for
// each vote into a queue; an independent negedge monitor pops and compares
// every accepted byte, checks stall stability and the done pulse.
// ---------------------------------------------------------------------------
module tb_vote_result_tx;

  localparam int COUNT_W = 32;
  localparam int NB      = COUNT_W / 8;
`ifdef VOTE_RESULT_CHECKSUM_EN
  localparam int FLEN = 3 + 3 * (1 + NB);
`else
  localparam int FLEN = 2 + 3 * (1 + NB);
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_voting_over = 1'b0;
  logic [COUNT_W-1:0] i_count1 = '0;
  logic [COUNT_W-1:0] i_count2 = '0;
  logic [COUNT_W-1:0] i_count3 = '0;
  logic               i_tx_ready = 1'b0;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic [1:0]         o_winner;
  logic               o_busy;
  logic               o_done;

  typedef struct {
    logic [7:0] data;
    bit         first;
    logic [1:0] win;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         acceptedCount = 0;
  int         doneSeen = 0;
  int         expectedFrames = 0;
  bit         expectDoneNext = 1'b0;
  bit         prevStall = 1'b0;
  int         readyMode = 0;
  int         stallLeft = 0;
  logic [1:0] expWin = 2'd0;
  logic [7:0] t1 [18];

  vote_result_tx #(
    .COUNT_W (COUNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_voting_over (i_voting_over),
    .i_count1      (i_count1),
    .i_count2      (i_count2),
    .i_count3      (i_count3),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_winner      (o_winner),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: winner is the unique holder of the maximum, else 0
  task automatic pushModelFrame(input logic [31:0] c1, input logic [31:0] c2,
                                input logic [31:0] c3, output logic [1:0] win);
    logic [31:0] cs [3];
    logic [31:0] mx;
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    int          n;
    cs[0] = c1; cs[1] = c2; cs[2] = c3;
    mx = c1;
    if (c2 > mx) mx = c2;
    if (c3 > mx) mx = c3;
    n = 0;
    win = 2'd0;
    for (int c = 0; c < 3; c++) begin
      if (cs[c] == mx) begin
        n++;
        win = 2'(c + 1);
      end
    end
    if (n > 1) win = 2'd0;
    bytes.push_back(8'hA5);
    for (int c = 0; c < 3; c++) begin
      bytes.push_back(8'(c + 1));
      for (int b = NB - 1; b >= 0; b--) bytes.push_back(cs[c][b*8 +: 8]);
    end
    bytes.push_back({6'b000000, win});
`ifdef VOTE_RESULT_CHECKSUM_EN
    x = 8'h00;
    foreach (bytes[i]) x = x ^ bytes[i];
    bytes.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (bytes[i]) expQ.push_back('{bytes[i], (i == 0), win});
  endtask

  // Ready driver: tied high, random, or a 3-cycle stall on byte index 6
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: i_tx_ready = 1'b1;
        1: i_tx_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (acceptedCount == 6 && stallLeft > 0) begin
            i_tx_ready = 1'b0;
            stallLeft--;
          end else begin
            i_tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: inputs only change just after posedge, so what is seen here is
  // exactly what the DUT samples at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (expectDoneNext) begin
      checkOutput("done_pulse", o_done, 1);
      expectDoneNext = 1'b0;
    end else if (o_done) begin
      checkOutput("spurious_done", o_done, 0);
    end
    if (o_done) doneSeen++;
    if (prevStall) checkOutput("stall_valid", o_tx_valid, 1);
    prevStall = o_tx_valid && !i_tx_ready;
    if (o_tx_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte actual=%0h required=none at %0t", o_tx_data, $time);
      end else if (i_tx_ready) begin
        e = expQ.pop_front();
        checkOutput("frame_byte", o_tx_data, e.data);
        if (e.first) checkOutput("winner_at_header", o_winner, e.win);
        acceptedCount++;
        if (expQ.size() == 0) expectDoneNext = 1'b1;
      end else begin
        checkOutput("stall_hold", o_tx_data, expQ[0].data);
      end
    end
  end

  // Raise voting-over and check the start timing. Caller is at posedge+#1
  // with the DUT idle and voting-over low.
  task automatic applyStimulus(input logic [31:0] c1, input logic [31:0] c2,
                               input logic [31:0] c3, input bit useT1);
    logic [1:0] win;
    i_count1 = c1;
    i_count2 = c2;
    i_count3 = c3;
    acceptedCount = 0;
    if (useT1) begin
      win = 2'd2;
      for (int i = 0; i < FLEN; i++) expQ.push_back('{t1[i], (i == 0), 2'd2});
    end else begin
      pushModelFrame(c1, c2, c3, win);
    end
    expWin = win;
    expectedFrames++;
    i_voting_over = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_latch", o_busy, 1);
    i_count1 = $urandom;
    i_count2 = $urandom;
    i_count3 = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("valid_before_k3", o_tx_valid, 0);
    @(posedge clk); #1;
    checkOutput("valid_at_k3", o_tx_valid, 1);
    checkOutput("winner_at_k3", o_winner, win);
  endtask

  task automatic waitFrameEnd();
    for (int n = 0; n < 400 && doneSeen < expectedFrames; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("frame_complete", doneSeen, expectedFrames);
  endtask

  task automatic releaseOver();
    i_voting_over = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_frame", o_busy, 0);
    checkOutput("winner_hold", o_winner, expWin);
    checkOutput("queue_empty", expQ.size(), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sel;
    logic [31:0] a, b, c;
    t1 = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h02, 8'h00, 8'h00,
           8'h00, 8'h09, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'hA9};
    readyMode = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", o_tx_valid, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_winner", o_winner, 0);
    checkOutput("reset_data", o_tx_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] test 1: counts 5 9 2, ready high");
    applyStimulus(5, 9, 2, 1'b1);
    waitFrameEnd();
    releaseOver();

    $display("[TB] test 2: ties");
    applyStimulus(7, 7, 3, 1'b0);
    waitFrameEnd();
    releaseOver();
    applyStimulus(0, 0, 0, 1'b0);
    waitFrameEnd();
    releaseOver();

    $display("[TB] test 3: stall on byte index 6");
    stallLeft = 3;
    readyMode = 2;
    applyStimulus(5, 9, 2, 1'b0);
    waitFrameEnd();
    checkOutput("stall_applied", stallLeft, 0);
    releaseOver();
    readyMode = 0;

    $display("[TB] test 4: voting-over held and toggled during send");
    applyStimulus(11, 4, 30, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    i_voting_over = 1'b0;
    @(posedge clk); #1;
    i_voting_over = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    i_voting_over = 1'b0;
    @(posedge clk); #1;
    i_voting_over = 1'b1;
    waitFrameEnd();
    repeat (70) begin @(posedge clk); #1; end
    checkOutput("single_frame", doneSeen, expectedFrames);
    releaseOver();

    $display("[TB] test 5: reset mid-frame");
    applyStimulus(100, 200, 300, 1'b0);
    for (int n = 0; n < 50 && acceptedCount != 10; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("reached_idx10", acceptedCount, 10);
    rst = 1'b1;
    i_voting_over = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_valid", o_tx_valid, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_winner", o_winner, 0);
    expQ.delete();
    expectDoneNext = 1'b0;
    expectedFrames--;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8, 1, 8, 1'b0);
    waitFrameEnd();
    releaseOver();

    $display("[TB] random frames");
    readyMode = 1;
    for (int r = 0; r < 20; r++) begin
      sel = int'($urandom_range(0, 3));
      a = $urandom; b = $urandom; c = $urandom;
      case (sel)
        1: begin
          a = $urandom_range(0, 1000);
          b = a;
          c = $urandom_range(0, 1000);
        end
        2: begin
          b = a;
          c = a;
        end
        3: begin
          a = $urandom_range(0, 3);
          b = $urandom_range(0, 3);
          c = $urandom_range(0, 3);
        end
        default: begin
        end
      endcase
      applyStimulus(a, b, c, 1'b0);
      waitFrameEnd();
      releaseOver();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    readyMode = 0;

    repeat (5) begin @(posedge clk); #1; end
    checkOutput("done_total", doneSeen, expectedFrames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
